// File: rtl/mrr_pathway_output_arbiter.sv
// Merges NUM_PATHWAYS AXI-stream decode pathways into one output stream.
// Each granted packet is prefixed with a header word {tag, grant, seq}.
//
// Ports:
//   clk, rst        single clock, synchronous active-high reset
//   i_tdata         packed per-pathway data, pathway p at [DW*(p+1)-1 -: DW]
//   i_tvalid/i_tlast/i_tready  per-pathway stream handshake
//   pathway_enable  per-pathway gate on new grants
//   o_tdata/o_tvalid/o_tlast/o_tready  merged output stream
//   grant_idx       granted pathway, 0 when idle
//   busy            high while a header or packet is in flight
//   pkt_count       packets completed since reset (wraps)
module mrr_pathway_output_arbiter #(
  parameter int         NUM_PATHWAYS = 4,
  parameter int         DATA_WIDTH   = 32,
  parameter logic [7:0] HDR_TAG      = 8'hA5
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [DATA_WIDTH*NUM_PATHWAYS-1:0]   i_tdata,
  input  logic [NUM_PATHWAYS-1:0]              i_tvalid,
  input  logic [NUM_PATHWAYS-1:0]              i_tlast,
  output logic [NUM_PATHWAYS-1:0]              i_tready,
  input  logic [NUM_PATHWAYS-1:0]              pathway_enable,
  output logic [DATA_WIDTH-1:0]                o_tdata,
  output logic                                 o_tvalid,
  output logic                                 o_tlast,
  input  logic                                 o_tready,
  output logic [3:0]                           grant_idx,
  output logic                                 busy,
  output logic [15:0]                          pkt_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  localparam logic [4:0] NP5 = 5'(NUM_PATHWAYS);

  logic [1:0]  state;
  logic [3:0]  grant;
  logic [3:0]  last_grant;
  logic [15:0] pkt_q;

  logic is_idle;
  logic is_hdr;
  logic is_data;

  assign is_idle = (state == S_IDLE);
  assign is_hdr  = (state == S_HDR);
  assign is_data = (state == S_DATA);

  // Per-pathway signals widened to 16 entries so a
  // 4-bit grant indexes them without range issues.
  logic [15:0]           elig;
  logic [15:0]           vld16;
  logic [15:0]           last16;
  logic [DATA_WIDTH-1:0] words [16];

  always_comb begin
    elig   = '0;
    vld16  = '0;
    last16 = '0;
    for (int p = 0; p < 16; p++) begin
      words[p] = '0;
    end
    for (int p = 0; p < NUM_PATHWAYS; p++) begin
      elig[p]   = i_tvalid[p] & pathway_enable[p];
      vld16[p]  = i_tvalid[p];
      last16[p] = i_tlast[p];
      words[p]  = i_tdata[DATA_WIDTH*p +: DATA_WIDTH];
    end
  end

  // Round-robin: scan last_grant+1 .. last_grant+N,
  // wrapping at NUM_PATHWAYS, first eligible wins.
  logic [3:0] rr_pick;
  logic       rr_hit;
  logic [4:0] cand;

  always_comb begin
    rr_pick = '0;
    rr_hit  = 1'b0;
    cand    = '0;
    for (int i = 1; i <= NUM_PATHWAYS; i++) begin
      cand = {1'b0, last_grant} + 5'(i);
      if (cand >= NP5) begin
        cand = cand - NP5;
      end
      if (!rr_hit && elig[cand[3:0]]) begin
        rr_hit  = 1'b1;
        rr_pick = cand[3:0];
      end
    end
  end

  logic hs;
  logic done;

  assign hs   = is_data & vld16[grant] & o_tready;
  assign done = hs & last16[grant];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      grant      <= '0;
      last_grant <= 4'(NUM_PATHWAYS - 1);
      pkt_q      <= '0;
    end else begin
      unique case (1'b1)
        is_idle: begin
          if (rr_hit) begin
            grant <= rr_pick;
            state <= S_HDR;
          end
        end
        is_hdr: begin
          if (o_tready) begin
            state <= S_DATA;
          end
        end
        is_data: begin
          // enable is not re-checked here: a granted
          // packet always runs to its tlast
          if (done) begin
            state      <= S_IDLE;
            last_grant <= grant;
            grant      <= '0;
            pkt_q      <= pkt_q + 16'd1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Header: {tag, 4'b0, grant, seq}, seq being the
  // completed-packet count; fitted to DATA_WIDTH
  // keeping the low bits.
  logic [31:0]           hdr32;
  logic [DATA_WIDTH-1:0] hdr_word;

  assign hdr32 = {HDR_TAG, 4'b0, grant, pkt_q};

  if (DATA_WIDTH == 32) begin : g_hdr_eq
    assign hdr_word = hdr32;
  end else if (DATA_WIDTH > 32) begin : g_hdr_ext
    assign hdr_word = {{(DATA_WIDTH-32){1'b0}}, hdr32};
  end else begin : g_hdr_trunc
    assign hdr_word = hdr32[DATA_WIDTH-1:0];
  end

  // Outputs are forced low while rst is high so the
  // stream is quiet before the reset edge lands.
  always_comb begin
    o_tdata  = '0;
    o_tvalid = 1'b0;
    o_tlast  = 1'b0;
    i_tready = '0;
    if (!rst) begin
      unique case (1'b1)
        is_hdr: begin
          o_tvalid = 1'b1;
          o_tdata  = hdr_word;
        end
        is_data: begin
          o_tvalid = vld16[grant];
          o_tlast  = last16[grant];
          o_tdata  = words[grant];
          for (int p = 0; p < NUM_PATHWAYS; p++) begin
            i_tready[p] = (grant == 4'(p)) & o_tready;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy      = (is_hdr | is_data) & ~rst;
  assign grant_idx = grant;
  assign pkt_count = pkt_q;

endmodule

// File: tb/tb_mrr_pathway_output_arbiter.sv
// Directed bench for mrr_pathway_output_arbiter.
// Scoreboard queue checked by an independent monitor.
module tb_mrr_pathway_output_arbiter;

  localparam int NP = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [127:0]  i_tdata;
  logic [3:0]    i_tvalid;
  logic [3:0]    i_tlast;
  logic [3:0]    i_tready;
  logic [3:0]    pathway_enable;
  logic [31:0]   o_tdata;
  logic          o_tvalid;
  logic          o_tlast;
  logic          o_tready;
  logic [3:0]    grant_idx;
  logic          busy;
  logic [15:0]   pkt_count;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
    logic [3:0]  g;
  } exp_t;

  exp_t        exp_q [$];
  logic [32:0] srcq [NP][$];
  logic [3:0]  src_go;
  logic        gap_chk;
  logic        toggle_rdy;

  mrr_pathway_output_arbiter #(
    .NUM_PATHWAYS(4),
    .DATA_WIDTH(32),
    .HDR_TAG(8'hA5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_tdata(i_tdata),
    .i_tvalid(i_tvalid),
    .i_tlast(i_tlast),
    .i_tready(i_tready),
    .pathway_enable(pathway_enable),
    .o_tdata(o_tdata),
    .o_tvalid(o_tvalid),
    .o_tlast(o_tlast),
    .o_tready(o_tready),
    .grant_idx(grant_idx),
    .busy(busy),
    .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  task automatic refresh();
    for (int p = 0; p < NP; p++) begin
      if (src_go[p] && srcq[p].size() > 0) begin
        i_tvalid[p]        = 1'b1;
        i_tdata[32*p +: 32] = srcq[p][0][31:0];
        i_tlast[p]         = srcq[p][0][32];
      end else begin
        i_tvalid[p]        = 1'b0;
        i_tdata[32*p +: 32] = '0;
        i_tlast[p]         = 1'b0;
      end
    end
  endtask

  task automatic push_exp(logic [31:0] d, logic l, int g);
    exp_t e;
    e.d = d;
    e.l = l;
    e.g = 4'(g);
    exp_q.push_back(e);
  endtask

  task automatic push_src(int p, logic [31:0] d, logic l);
    srcq[p].push_back({l, d});
  endtask

  task automatic send(int p, int n, logic [31:0] base, logic [31:0] hdr);
    push_exp(hdr, 1'b0, p);
    for (int k = 0; k < n; k++) begin
      push_src(p, base + 32'(k), k == n - 1);
      push_exp(base + 32'(k), k == n - 1, p);
    end
  endtask

  task automatic wait_size(int n, int lim);
    bit ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() <= n) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL drain_timeout: left %0d want <= %0d", exp_q.size(), n);
    end
  endtask

  // Source model: a word leaves its queue on a handshake.
  initial begin
    logic [3:0] acc;
    forever begin
      @(negedge clk);
      acc = i_tvalid & i_tready;
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++) begin
        if (acc[p]) begin
          void'(srcq[p].pop_front());
        end
      end
      refresh();
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (toggle_rdy) begin
        o_tready = ~o_tready;
      end
    end
  end

  // Monitor: scoreboard pops, stall stability, idle gap.
  initial begin
    logic        pstall = 1'b0;
    logic [31:0] pd = '0;
    logic        pl = 1'b0;
    logic        pbusy = 1'b0;
    logic        armed = 1'b0;
    int          since = 0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        pstall = 1'b0;
        pbusy  = 1'b0;
        armed  = 1'b0;
      end else begin
        if (pstall) begin
          chk("stall_valid", 32'(o_tvalid), 32'd1);
          chk("stall_data", o_tdata, pd);
          chk("stall_last", 32'(o_tlast), 32'(pl));
        end
        if (armed) begin
          since++;
        end
        if (busy && !pbusy && gap_chk && armed) begin
          chk("idle_gap", 32'(since), 32'd2);
          armed = 1'b0;
        end
        if (o_tvalid && o_tready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_word: got %h want none", o_tdata);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", o_tdata, e.d);
            chk("out_last", 32'(o_tlast), 32'(e.l));
            chk("out_grant", 32'(grant_idx), 32'(e.g));
          end
          if (o_tlast) begin
            armed = 1'b1;
            since = 0;
          end
        end
        pstall = o_tvalid && !o_tready;
        pd     = o_tdata;
        pl     = o_tlast;
        pbusy  = busy;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_tdata        = '0;
    i_tvalid       = '0;
    i_tlast        = '0;
    pathway_enable = 4'hF;
    o_tready       = 1'b1;
    src_go         = '0;
    gap_chk        = 1'b0;
    toggle_rdy     = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(o_tvalid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(i_tready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("init_valid", 32'(o_tvalid), 32'd0);
    chk("init_data", o_tdata, 32'd0);
    chk("init_busy", 32'(busy), 32'd0);
    chk("init_grant", 32'(grant_idx), 32'd0);
    chk("init_count", 32'(pkt_count), 32'd0);

    // all four requesting: order 0,1,2,3,0
    gap_chk = 1'b1;
    send(0, 2, 32'h1000_0000, 32'hA500_0000);
    send(1, 2, 32'h1100_0000, 32'hA501_0001);
    send(2, 2, 32'h1200_0000, 32'hA502_0002);
    send(3, 2, 32'h1300_0000, 32'hA503_0003);
    send(0, 2, 32'h1000_0010, 32'hA500_0004);
    @(posedge clk);
    #1;
    src_go = 4'hF;
    refresh();
    wait_size(0, 200);
    gap_chk = 1'b0;
    @(negedge clk);
    chk("count_rr", 32'(pkt_count), 32'd5);

    // single request on pathway 2, header latency
    @(posedge clk);
    #1;
    send(2, 3, 32'h2200_0000, 32'hA502_0005);
    refresh();
    @(negedge clk);
    chk("lat_idle", 32'(o_tvalid), 32'd0);
    @(negedge clk);
    chk("lat_hdr_valid", 32'(o_tvalid), 32'd1);
    chk("lat_hdr_data", o_tdata, 32'hA502_0005);
    wait_size(0, 100);
    @(negedge clk);
    chk("count_single", 32'(pkt_count), 32'd6);

    // backpressure toggling
    @(posedge clk);
    #1;
    toggle_rdy = 1'b1;
    send(3, 2, 32'h3300_0000, 32'hA503_0006);
    send(1, 4, 32'h3100_0000, 32'hA501_0007);
    refresh();
    wait_size(0, 300);
    toggle_rdy = 1'b0;
    o_tready   = 1'b1;
    @(negedge clk);
    chk("count_bp", 32'(pkt_count), 32'd8);

    // disabled pathway 1, one-word packet on 3
    @(posedge clk);
    #1;
    pathway_enable = 4'b1101;
    send(3, 1, 32'h4300_0000, 32'hA503_0008);
    send(1, 2, 32'h4100_0000, 32'hA501_0009);
    refresh();
    wait_size(3, 100);
    repeat (6) begin
      @(negedge clk);
      chk("dis_ready", 32'(i_tready[1]), 32'd0);
      chk("dis_busy", 32'(busy), 32'd0);
    end
    @(posedge clk);
    #1 pathway_enable = 4'hF;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (busy) break;
    end
    chk("reen_busy", 32'(busy), 32'd1);
    pathway_enable = 4'b1101;
    wait_size(0, 100);
    pathway_enable = 4'hF;
    @(negedge clk);
    chk("count_en", 32'(pkt_count), 32'd10);

    // reset during DATA of pathway 0
    @(posedge clk);
    #1;
    push_exp(32'hA500_000A, 1'b0, 0);
    for (int k = 0; k < 4; k++) begin
      push_src(0, 32'h5000_0000 + 32'(k), k == 3);
    end
    push_exp(32'h5000_0000, 1'b0, 0);
    push_exp(32'h5000_0001, 1'b0, 0);
    refresh();
    wait_size(0, 100);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 32'(o_tvalid), 32'd0);
    chk("mid_rst_last", 32'(o_tlast), 32'd0);
    chk("mid_rst_data", o_tdata, 32'd0);
    chk("mid_rst_ready", 32'(i_tready), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    push_exp(32'hA500_0000, 1'b0, 0);
    push_exp(32'h5000_0002, 1'b0, 0);
    push_exp(32'h5000_0003, 1'b1, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 32'(o_tvalid), 32'd0);
    chk("post_rst_data", o_tdata, 32'd0);
    chk("post_rst_ready", 32'(i_tready), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_count", 32'(pkt_count), 32'd0);
    chk("post_rst_grant", 32'(grant_idx), 32'd0);
    wait_size(0, 100);
    @(negedge clk);
    chk("count_after_rst", 32'(pkt_count), 32'd1);

    // counter wrap at 0xFFFF
    @(posedge clk);
    #1;
    force dut.pkt_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.pkt_q;
    send(2, 1, 32'h6200_0000, 32'hA502_FFFF);
    refresh();
    wait_size(0, 50);
    @(negedge clk);
    chk("count_wrap", 32'(pkt_count), 32'd0);
    @(posedge clk);
    #1;
    send(3, 1, 32'h6300_0000, 32'hA503_0000);
    refresh();
    wait_size(0, 50);
    @(negedge clk);
    chk("count_after_wrap", 32'(pkt_count), 32'd1);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
